// File: rtl/wb_spi_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_spi_cmd_master
//
// Purpose:
//   Wishbone classic single-cycle bus master placed directly in front of the
//   SPI core's Wishbone slave port. It turns each command taken from a
//   valid/ready command stream into exactly one Wishbone cycle. It returns the
//   read data and status on a valid/ready response stream. A cycle that gets
//   no ack/err within TIMEOUT_CYCLES cycles is closed with a timeout error.
//   The slave interrupt line is registered before it is passed upstream.
//
// Optional feature (compile-time macro WB_SPI_CMD_MASTER_IRQ_LATCH_EN):
//   defined   : irq_o is sticky. It is set on a rising edge of the registered
//               wb_int_i and cleared by irq_clr_i. If set and clear happen in
//               the same cycle, set wins.
//   undefined : irq_o is wb_int_i delayed by one flop, and irq_clr_i is ignored.
//
// Parameters:
//   TIMEOUT_CYCLES : cycles a bus cycle may stay open (0 disables the timeout)
//   TIMEOUT_W      : timeout counter width (TIMEOUT_CYCLES < 2**TIMEOUT_W)
//
// Ports:
//   wb_clk_i, wb_rst_i              clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o         command handshake
//   cmd_we_i/adr_i/dat_i/sel_i      command fields
//   rsp_valid_o/rsp_ready_i         response handshake
//   rsp_dat_o/err_o/timeout_o       response fields
//   wb_adr_o/dat_o/sel_o/we_o/stb_o/cyc_o   master outputs to the slave
//   wb_dat_i/ack_i/err_i/int_i      slave outputs to the master
//   irq_o, irq_clr_i                upstream interrupt and its clear
// -----------------------------------------------------------------------------
module wb_spi_cmd_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [4:0]  cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_int_i,
  output logic        irq_o,
  input  logic        irq_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam bit                   C_TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] C_CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] C_CNT_MAX  = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] C_CNT_ONE  = TIMEOUT_W'(1);

  state_t                r_state, w_state;
  logic [4:0]            r_adr, w_adr;
  logic [31:0]           r_dat, w_dat;
  logic [3:0]            r_sel, w_sel;
  logic                  r_we, w_we;
  logic                  r_cyc, w_cyc;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [31:0]           r_rsp_dat, w_rsp_dat;
  logic                  r_rsp_err, w_rsp_err;
  logic                  r_rsp_to, w_rsp_to;
  logic [TIMEOUT_W-1:0]  r_cnt, w_cnt;
  logic                  w_term;
  logic                  r_irq, w_irq;

  // Next-state and next-output logic. All outputs are registered below.
  always_comb begin
    w_state     = r_state;
    w_adr       = r_adr;
    w_dat       = r_dat;
    w_sel       = r_sel;
    w_we        = r_we;
    w_cyc       = r_cyc;
    w_rsp_valid = r_rsp_valid;
    w_rsp_dat   = r_rsp_dat;
    w_rsp_err   = r_rsp_err;
    w_rsp_to    = r_rsp_to;
    w_cnt       = r_cnt;
    w_term      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_adr   = cmd_adr_i;
          w_dat   = cmd_dat_i;
          w_sel   = cmd_sel_i;
          w_we    = cmd_we_i;
          w_cyc   = 1'b1;
          w_cnt   = {TIMEOUT_W{1'b0}};
          w_state = ST_BUS;
        end else begin
          // adr/dat/sel keep their last value; only we and cyc return low
          w_we  = 1'b0;
          w_cyc = 1'b0;
        end
      end
      ST_BUS: begin
        // err outranks a simultaneous ack, and both outrank the timeout
        if (wb_err_i) begin
          w_term    = 1'b1;
          w_rsp_err = 1'b1;
          w_rsp_to  = 1'b0;
          w_rsp_dat = 32'h0000_0000;
        end else if (wb_ack_i) begin
          w_term    = 1'b1;
          w_rsp_err = 1'b0;
          w_rsp_to  = 1'b0;
          w_rsp_dat = r_we ? 32'h0000_0000 : wb_dat_i;
        end else if (C_TO_EN && (r_cnt == C_CNT_LAST)) begin
          w_term    = 1'b1;
          w_rsp_err = 1'b1;
          w_rsp_to  = 1'b1;
          w_rsp_dat = 32'h0000_0000;
        end else begin
          // saturate so a disabled timeout never wraps the counter
          if (r_cnt != C_CNT_MAX) begin
            w_cnt = r_cnt + C_CNT_ONE;
          end else begin
            w_cnt = r_cnt;
          end
        end
        if (w_term) begin
          w_cyc       = 1'b0;
          w_we        = 1'b0;
          w_rsp_valid = 1'b1;
          w_state     = ST_RESP;
        end else begin
          w_state = ST_BUS;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid = 1'b0;
          w_state     = ST_IDLE;
        end else begin
          w_state = ST_RESP;
        end
      end
      default: begin
        w_state     = ST_IDLE;
        w_cyc       = 1'b0;
        w_we        = 1'b0;
        w_rsp_valid = 1'b0;
      end
    endcase
  end

  // State and registered bus/response outputs. Reset drops the bus immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_adr       <= 5'h00;
      r_dat       <= 32'h0000_0000;
      r_sel       <= 4'h0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_cnt       <= {TIMEOUT_W{1'b0}};
    end else begin
      r_state     <= w_state;
      r_adr       <= w_adr;
      r_dat       <= w_dat;
      r_sel       <= w_sel;
      r_we        <= w_we;
      r_cyc       <= w_cyc;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_dat   <= w_rsp_dat;
      r_rsp_err   <= w_rsp_err;
      r_rsp_to    <= w_rsp_to;
      r_cnt       <= w_cnt;
    end
  end

`ifdef WB_SPI_CMD_MASTER_IRQ_LATCH_EN
  logic r_int_q;

  // Sticky interrupt: a rise of the registered line sets it, and set wins over clear.
  always_comb begin
    w_irq = (wb_int_i & ~r_int_q) | (r_irq & ~irq_clr_i);
  end

  // Interrupt input register and sticky flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_int_q <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_int_q <= wb_int_i;
      r_irq   <= w_irq;
    end
  end
`else
  logic w_unused_irq_clr;
  assign w_unused_irq_clr = irq_clr_i;

  // Level-following interrupt: one flop of delay.
  always_comb begin
    w_irq = wb_int_i;
  end

  // Interrupt delay flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq;
    end
  end
`endif

  assign cmd_ready_o   = (r_state == ST_IDLE);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_dat_o     = r_rsp_dat;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_to;
  assign wb_adr_o      = r_adr;
  assign wb_dat_o      = r_dat;
  assign wb_sel_o      = r_sel;
  assign wb_we_o       = r_we;
  assign wb_stb_o      = r_cyc;
  assign wb_cyc_o      = r_cyc;
  assign irq_o         = r_irq;

endmodule
